// File: rtl/fifo_ctrl_circ.sv
// ---------------------------------------------------------------------------
// fifo_ctrl_circ
//
// Circular-buffer FIFO with its own storage, read/write pointers, a separate
// occupancy counter, programmable almost-full / almost-empty thresholds, a
// registered read port with a one-cycle valid strobe, and sticky
// overflow / underflow error flags.
//
// Parameters
//   WIDTH     data word width in bits
//   DEPTH     number of entries (power of two, >= 2)
//   AFULL_TH  afull_o when count_o >= AFULL_TH   (1..DEPTH)
//   AEMPTY_TH aempty_o when count_o <= AEMPTY_TH (0..DEPTH-1)
//
// Ports
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-high reset
//   push_i     write request, data_i sampled on the same edge
//   pop_i      read request
//   data_i     write data
//   clr_err_i  synchronous clear of ovf_o / udf_o (a same-edge set wins)
//   data_o     registered read data, holds when no pop is accepted
//   valid_o    data_o carries a freshly popped word this cycle
//   count_o    occupancy, 0..DEPTH
//   full_o     count_o == DEPTH
//   empty_o    count_o == 0
//   pnding_o   at least one word is stored
//   afull_o    almost-full
//   aempty_o   almost-empty
//   ovf_o      sticky: a push was rejected
//   udf_o      sticky: a pop was rejected
// ---------------------------------------------------------------------------
module fifo_ctrl_circ #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     clr_err_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     pnding_o,
  output logic                     afull_o,
  output logic                     aempty_o,
  output logic                     ovf_o,
  output logic                     udf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_ovf;
  logic             r_udf;

  logic             w_pop_acc;
  logic             w_push_acc;
  logic [CW-1:0]    w_count_nxt;

  // Acceptance: a pop frees a slot in the same cycle, so a full FIFO still
  // accepts a push when a pop is accepted alongside it.
  always_comb begin
    w_pop_acc  = pop_i && (r_count != {CW{1'b0}});
    w_push_acc = push_i && ((r_count != DEPTH_C) || w_pop_acc);
  end

  // Next occupancy from the accepted push/pop combination.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_acc, w_pop_acc})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage array write; the array is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (w_push_acc) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  // Pointers and occupancy; pointers wrap by natural overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_acc) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // Registered read port: data holds between pops, valid is a single-cycle strobe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data  <= {WIDTH{1'b0}};
      r_valid <= 1'b0;
    end else begin
      if (w_pop_acc) begin
        r_data <= r_mem[r_rd_ptr];
      end
      r_valid <= w_pop_acc;
    end
  end

  // Sticky error flags; a rejection on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (push_i && !w_push_acc) begin
        r_ovf <= 1'b1;
      end else if (clr_err_i) begin
        r_ovf <= 1'b0;
      end
      if (pop_i && !w_pop_acc) begin
        r_udf <= 1'b1;
      end else if (clr_err_i) begin
        r_udf <= 1'b0;
      end
    end
  end

  // Status decode straight from the count register, so flags never glitch.
  always_comb begin
    count_o  = r_count;
    full_o   = (r_count == DEPTH_C);
    empty_o  = (r_count == {CW{1'b0}});
    pnding_o = (r_count != {CW{1'b0}});
    afull_o  = (r_count >= AFULL_C);
    aempty_o = (r_count <= AEMPTY_C);
    data_o   = r_data;
    valid_o  = r_valid;
    ovf_o    = r_ovf;
    udf_o    = r_udf;
  end

endmodule

// File: tb/tb_fifo_ctrl_circ.sv
module tb_fifo_ctrl_circ;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int AF = 3;
  localparam int AE = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         push;
  logic         pop;
  logic         clr;
  logic [W-1:0] din;
  logic [W-1:0] dout;
  logic         valid;
  logic [2:0]   cnt;
  logic         full, empty, pnd, afull, aempty, ovf, udf;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a plain queue plus the visible read/flag state.
  logic [W-1:0] q[$];
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ovf;
  logic         m_udf;

  fifo_ctrl_circ #(
    .WIDTH(W), .DEPTH(D), .AFULL_TH(AF), .AEMPTY_TH(AE)
  ) dut (
    .clk_i(clk), .rst_i(rst), .push_i(push), .pop_i(pop), .data_i(din),
    .clr_err_i(clr), .data_o(dout), .valid_o(valid), .count_o(cnt),
    .full_o(full), .empty_o(empty), .pnding_o(pnd), .afull_o(afull),
    .aempty_o(aempty), .ovf_o(ovf), .udf_o(udf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check_eq("count",  32'(cnt),    32'(n));
    check_eq("full",   32'(full),   32'(n == D));
    check_eq("empty",  32'(empty),  32'(n == 0));
    check_eq("pnding", 32'(pnd),    32'(n != 0));
    check_eq("afull",  32'(afull),  32'(n >= AF));
    check_eq("aempty", 32'(aempty), 32'(n <= AE));
    check_eq("valid",  32'(valid),  32'(m_valid));
    check_eq("data",   32'(dout),   32'(m_data));
    check_eq("ovf",    32'(ovf),    32'(m_ovf));
    check_eq("udf",    32'(udf),    32'(m_udf));
  endtask

  // One clock: drive inputs, advance the model over the edge, check on the falling edge.
  task automatic step(input logic p, input logic po, input logic [W-1:0] d, input logic c);
    bit pop_ok, push_ok;
    push = p; pop = po; din = d; clr = c;
    @(posedge clk);
    pop_ok  = po && (q.size() > 0);
    push_ok = p && ((q.size() < D) || pop_ok);
    if (pop_ok) begin
      m_data  = q.pop_front();
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (push_ok) q.push_back(d);
    if (p && !push_ok) m_ovf = 1'b1;
    else if (c)        m_ovf = 1'b0;
    if (po && !pop_ok) m_udf = 1'b1;
    else if (c)        m_udf = 1'b0;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; clr = 1'b0; din = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_all();
    @(negedge clk);

    // Idle cycles after reset.
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);

    // Fill with A0..A3, then drain on four consecutive cycles.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, W'(16'hA0 + i), 1'b0);
    check_eq("full_after_4_push", 32'(full), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, '0, 1'b0);
      check_eq("drain_data", 32'(dout), 32'(16'hA0 + i));
      check_eq("drain_valid", 32'(valid), 32'd1);
    end
    check_eq("empty_after_drain", 32'(empty), 32'd1);
    step(1'b0, 1'b0, '0, 1'b0);
    check_eq("valid_drops", 32'(valid), 32'd0);

    // Pointer wrap at constant fill level 2.
    step(1'b1, 1'b0, 16'h0100, 1'b0);
    step(1'b1, 1'b0, 16'h0101, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, W'(16'h0102 + i), 1'b0);
      check_eq("wrap_count", 32'(cnt), 32'd2);
      check_eq("wrap_data", 32'(dout), 32'(16'h0100 + i));
    end
    step(1'b0, 1'b1, '0, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);
    check_eq("wrap_tail", 32'(dout), 32'h010B);

    // Full FIFO with simultaneous push/pop of 0xB4.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, W'(16'hB0 + i), 1'b0);
    step(1'b1, 1'b1, 16'h00B4, 1'b0);
    check_eq("fullpp_count", 32'(cnt), 32'd4);
    check_eq("fullpp_ovf", 32'(ovf), 32'd0);
    check_eq("fullpp_oldest", 32'(dout), 32'h00B0);

    // Push while full: dropped, ovf sticks until cleared.
    step(1'b1, 1'b0, 16'h00EE, 1'b0);
    check_eq("ovf_set", 32'(ovf), 32'd1);
    step(1'b0, 1'b0, '0, 1'b0);
    check_eq("ovf_sticky", 32'(ovf), 32'd1);
    step(1'b1, 1'b0, 16'h00EF, 1'b1);
    check_eq("ovf_set_wins", 32'(ovf), 32'd1);
    step(1'b0, 1'b0, '0, 1'b1);
    check_eq("ovf_cleared", 32'(ovf), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, '0, 1'b0);
      check_eq("after_ovf_data", 32'(dout), 32'(16'hB1 + i));
    end
    step(1'b0, 1'b1, '0, 1'b0);
    check_eq("udf_set", 32'(udf), 32'd1);
    // Empty with push and pop together: push taken, pop rejected.
    step(1'b1, 1'b1, 16'h00D0, 1'b1);
    check_eq("emptypp_count", 32'(cnt), 32'd1);
    check_eq("emptypp_udf", 32'(udf), 32'd1);
    step(1'b0, 1'b1, '0, 1'b1);
    check_eq("emptypp_data", 32'(dout), 32'h00D0);
    check_eq("udf_cleared", 32'(udf), 32'd0);

    // Asynchronous reset mid-stream with count 3 and pop high.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, W'(16'h0C00 + i), 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);
    step(1'b1, 1'b0, 16'h0C03, 1'b0);
    check_eq("pre_rst_count", 32'(cnt), 32'd3);
    push = 1'b0; pop = 1'b1;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    pop = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all();
    @(negedge clk);
    step(1'b1, 1'b0, 16'h00C1, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);
    check_eq("post_rst_data", 32'(dout), 32'h00C1);

    // Randomized traffic, alternating push-heavy and pop-heavy phases.
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = ((i / 50) % 2 == 0) ? 75 : 25;
      step(($urandom_range(99) < bias), ($urandom_range(99) >= bias),
           W'($urandom), ($urandom_range(7) == 0));
    end
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom), 1'($urandom), W'($urandom), ($urandom_range(7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
